// File: rtl/vrf_write_arbiter.sv
// Round-robin arbiter folding NUM_REQ writers onto two register-file write ports; grants are combinational, write strobes land 1 cycle later.
// Backpressure: a requester holds req_val until req_rdy; ports with wr_rdy low are simply not used, same-index pairs are split across cycles.
module vrf_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 10,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_val,
    input  logic [NUM_REQ*IDX_W-1:0]  req_index,
    input  logic [NUM_REQ*DATA_W-1:0] req_msg,
    output logic [NUM_REQ-1:0]        req_rdy,
    input  logic                      wr_rdy_0,
    input  logic                      wr_rdy_1,
    output logic                      wr_val_0,
    output logic                      wr_val_1,
    output logic [IDX_W-1:0]          wr_index_0,
    output logic [IDX_W-1:0]          wr_index_1,
    output logic [DATA_W-1:0]         wr_msg_0,
    output logic [DATA_W-1:0]         wr_msg_1,
    output logic [PTR_W-1:0]          rr_ptr,
    output logic [15:0]               stall_cnt
);

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [15:0]        r_stall_cnt;
    logic               r_wr_val_0;
    logic               r_wr_val_1;
    logic [IDX_W-1:0]   r_wr_index_0;
    logic [IDX_W-1:0]   r_wr_index_1;
    logic [DATA_W-1:0]  r_wr_msg_0;
    logic [DATA_W-1:0]  r_wr_msg_1;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_any_rdy;
    logic               w_both_rdy;
    logic               w_g0_vld;
    logic               w_g1_vld;
    logic [PTR_W-1:0]   w_g0_id;
    logic [PTR_W-1:0]   w_g1_id;
    logic [IDX_W-1:0]   w_g0_index;
    logic               w_p0_vld;
    logic               w_p1_vld;
    logic [PTR_W-1:0]   w_p0_id;
    logic [PTR_W-1:0]   w_p1_id;
    logic [PTR_W-1:0]   w_last_id;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic               w_stall;

    assign w_any_rdy  = wr_rdy_0 | wr_rdy_1;
    assign w_both_rdy = wr_rdy_0 & wr_rdy_1;

    // Scan from the priority pointer; the second pick must not target the first pick's index.
    always_comb begin
        int k;
        k          = 0;
        w_g0_vld   = 1'b0;
        w_g1_vld   = 1'b0;
        w_g0_id    = '0;
        w_g1_id    = '0;
        w_g0_index = '0;
        w_grant    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            k = (int'(r_rr_ptr) + j) % NUM_REQ;
            if (reset_n && req_val[k] && w_any_rdy) begin
                if (!w_g0_vld) begin
                    w_g0_vld   = 1'b1;
                    w_g0_id    = PTR_W'(k);
                    w_g0_index = req_index[k*IDX_W +: IDX_W];
                    w_grant[k] = 1'b1;
                end else if (w_both_rdy && !w_g1_vld &&
                             req_index[k*IDX_W +: IDX_W] != w_g0_index) begin
                    w_g1_vld   = 1'b1;
                    w_g1_id    = PTR_W'(k);
                    w_grant[k] = 1'b1;
                end
            end
        end
    end

    // First pick takes port 0 when it is ready, otherwise port 1.
    always_comb begin
        w_p0_vld  = w_g0_vld & wr_rdy_0;
        w_p0_id   = w_g0_id;
        w_p1_vld  = wr_rdy_0 ? w_g1_vld : w_g0_vld;
        w_p1_id   = wr_rdy_0 ? w_g1_id : w_g0_id;
        w_last_id = w_g1_vld ? w_g1_id : w_g0_id;
        w_ptr_nxt = (int'(w_last_id) == NUM_REQ - 1) ? '0 : w_last_id + PTR_W'(1);
    end

    assign w_stall = |(req_val & ~w_grant);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr     <= '0;
            r_stall_cnt  <= '0;
            r_wr_val_0   <= 1'b0;
            r_wr_val_1   <= 1'b0;
            r_wr_index_0 <= '0;
            r_wr_index_1 <= '0;
            r_wr_msg_0   <= '0;
            r_wr_msg_1   <= '0;
        end else begin
            r_wr_val_0 <= w_p0_vld;
            r_wr_val_1 <= w_p1_vld;
            if (w_p0_vld) begin
                r_wr_index_0 <= req_index[int'(w_p0_id)*IDX_W +: IDX_W];
                r_wr_msg_0   <= req_msg[int'(w_p0_id)*DATA_W +: DATA_W];
            end
            if (w_p1_vld) begin
                r_wr_index_1 <= req_index[int'(w_p1_id)*IDX_W +: IDX_W];
                r_wr_msg_1   <= req_msg[int'(w_p1_id)*DATA_W +: DATA_W];
            end
            if (w_g0_vld) begin
                r_rr_ptr <= w_ptr_nxt;
            end
            if (w_stall && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign req_rdy    = w_grant;
    assign wr_val_0   = r_wr_val_0;
    assign wr_val_1   = r_wr_val_1;
    assign wr_index_0 = r_wr_index_0;
    assign wr_index_1 = r_wr_index_1;
    assign wr_msg_0   = r_wr_msg_0;
    assign wr_msg_1   = r_wr_msg_1;
    assign rr_ptr     = r_rr_ptr;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: doc/vrf_write_arbiter.md
VRF_WRITE_ARBITER -- requirements
Module: vrf_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, write data width.
REQ-003 SHALL have parameter IDX_W, default 10, register-file index width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_val  input  NUM_REQ  per-requester write-valid.
REQ-007 SHALL have port req_index  input  NUM_REQ*IDX_W  per-requester target index, requester i at bits [i*IDX_W +: IDX_W].
REQ-008 SHALL have port req_msg  input  NUM_REQ*DATA_W  per-requester write data, requester i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_rdy  output  NUM_REQ  per-requester grant, combinational.
REQ-010 SHALL have port wr_rdy_0 and wr_rdy_1  input  1 each  register-file write port k can accept this cycle.
REQ-011 SHALL have port wr_val_0 and wr_val_1  output  1 each  registered write strobe to register-file port k.
REQ-012 SHALL have port wr_index_0 and wr_index_1  output  IDX_W each  registered write index.
REQ-013 SHALL have port wr_msg_0 and wr_msg_1  output  DATA_W each  registered write data.
REQ-014 SHALL have port rr_ptr  output  ceil(log2 NUM_REQ)  current round-robin priority pointer.
REQ-015 SHALL have port stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-016 SHALL scan requesters in order rr_ptr, rr_ptr+1, ... mod NUM_REQ each cycle.
REQ-017 SHALL assign the first valid requester in scan order to the lowest-numbered port whose wr_rdy is high.
REQ-018 SHALL assign the next valid requester in scan order to the remaining ready port, only if its req_index differs from the first grant's index.
REQ-019 SHALL, on an index collision, skip the colliding requester and grant the next non-colliding valid requester instead; the skipped requester retries later.
REQ-020 SHALL grant at most 2 requesters per cycle, each at most once, and SHALL assert req_rdy[i] only for granted requesters.
REQ-021 SHALL grant nothing when both wr_rdy are low, and SHALL use a single port when exactly one wr_rdy is high.
REQ-022 SHALL complete a transfer when req_val[i] and req_rdy[i] are both high.
REQ-023 SHALL, at the next rising edge, drive wr_val_k=1 together with the captured index and data for each port granted; latency is exactly 1 cycle.
REQ-024 SHALL drive wr_val_k=0 for each port not granted and SHALL hold wr_index_k/wr_msg_k at their previous values.
REQ-025 SHALL update rr_ptr to (highest-scan-order granted requester + 1) mod NUM_REQ.
REQ-026 SHALL leave rr_ptr unchanged in any cycle with no grant.
REQ-027 SHALL increment stall_cnt by 1 in any cycle where some requester is valid but not granted, and SHALL saturate stall_cnt at 16'hFFFF.
REQ-028 SHALL ensure no requester with continuous req_val waits more than NUM_REQ cycles while at least one wr_rdy stays high.

Reset
REQ-029 SHALL, while reset_n=0 (asynchronously), clear wr_val_0/1, wr_index_0/1, wr_msg_0/1, rr_ptr and stall_cnt to 0, and SHALL hold req_rdy at 0.
REQ-030 SHALL discard any registered write that is in flight when reset asserts; no wr_val pulse is issued after reset_n rises without a new grant.
REQ-031 SHALL permit grants starting in the first cycle after reset_n deasserts.

Verification
REQ-032 Scenario: rr_ptr=0, req_val=4'b0101, indices 5/9, both wr_rdy=1 -> req_rdy=4'b0101; next cycle wr_val_0=1 with index 5, wr_val_1=1 with index 9; rr_ptr=3.
REQ-033 Scenario: req_val=4'b0011, both index 7, rr_ptr=0 -> only req 0 granted on port 0; req 1 granted next cycle; stall_cnt increments once.
REQ-034 Scenario: wr_rdy_0=0, wr_rdy_1=1, req_val=4'b1000 -> req 3 granted on port 1; next cycle wr_val_1=1, wr_val_0=0; rr_ptr=0.
REQ-035 Scenario: all 4 requesters valid continuously, distinct indices, both ports ready -> grant pairs {0,1},{2,3},{0,1},...; stall_cnt increments every cycle.
REQ-036 Scenario: reset_n pulled low mid-cycle after a grant -> wr_val_0/1 go 0 immediately, rr_ptr=0, stall_cnt=0; no write pulse after release.
REQ-037 Scenario: stall_cnt preloaded to 16'hFFFE and 3 stall cycles applied -> stall_cnt reads 16'hFFFF and holds.
